alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor of the single-cycle 32-bit ALU in the KGP-miniRISC datapath.
- Accepts operand/opcode transactions over a valid/ready handshake and returns registered results with carry/zero/sign/overflow flags.
- Supports add/sub/and/xor, four shifts, differing-bit index and increment.
- An optional iterative multiplier adds a multi-cycle stall path. The block sits between decode and writeback in the execute stage.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, minimum 8.
- TAG_W, 4, width of the sideband tag carried unchanged from input to output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block can accept an input this cycle.
- in_a  input  WIDTH  operand A (rs).
- in_b  input  WIDTH  operand B (rt, or shift amount).
- in_op  input  4  opcode; encoding in alu_pkg.
- in_tag  input  TAG_W  sideband tag (e.g. destination register).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_result  output  WIDTH  result.
- out_flags  output  4  {overflow, carry, zero, sign}, bits [3:0].
- out_tag  output  TAG_W  tag of this result.
- out_illegal  output  1  opcode was unsupported.

Behaviour:
- Reset:
  - Clears s1_valid, s2_valid and the multiplier FSM to IDLE.
  - out_valid=0, out_result=0, out_flags=0, out_tag=0, out_illegal=0.
  - in_ready=0 during the reset cycle, and 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight transactions, including a running multiply. No partial result is emitted.
- Handshake:
  - Transfer occurs when valid&&ready at a clock edge.
  - out_* are held stable while out_valid&&!out_ready.
  - in_ready does not depend on in_valid.
- Pipeline:
  - S1 registers a, b, op and tag on input transfer.
  - S2 registers the computed result, flags, tag and illegal on advance.
  - Latency is 2 edges from input transfer to out_valid.
  - s1_adv = s1_valid && op_done && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s1_adv.
  - Full throughput: one op per cycle, no bubble, under continuous out_ready.
  - Simultaneous output transfer and S1 advance reloads S2 in the same cycle.
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a+~b+1.
  - 2 AND.
  - 3 XOR.
  - 4 SLL.
  - 5 SRL.
  - 6 SLA, identical to SLL.
  - 7 SRA.
  - 8 DIFF: index of the lowest set bit of a^b, zero-extended; 0 when a==b.
  - 9 INC: b+1.
  - 10 MUL: optional, see Optional Feature.
  - 11-15 illegal: result=0, flags=0, out_illegal=1.
- Shifts:
  - The full in_b value is the amount.
  - Amount >= WIDTH gives 0 for SLL/SLA/SRL, and WIDTH copies of a[WIDTH-1] for SRA.
- Flags:
  - carry: adder carry-out for ADD/SUB/INC (SUB carry=1 means no borrow); 0 for all other ops.
  - overflow: signed overflow for ADD/SUB/INC; 0 otherwise.
  - zero: result==0.
  - sign: result[WIDTH-1].
- op_done is 1 for every op except MUL.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined:
  - op 10 is a WIDTH-cycle shift-add multiplier returning the low WIDTH bits of a*b.
  - FSM states: IDLE -> RUN when S1 holds MUL and s1_valid. RUN iterates WIDTH cycles (count 0..WIDTH-1) -> DONE. DONE asserts op_done, then returns to IDLE on s1_adv.
  - While in DONE with S2 stalled, the FSM stays in DONE.
  - MUL flags: carry=0, overflow=0; zero and sign follow the result.
  - in_ready=0 during RUN.
- Undefined: op 10 is illegal like 11-15, and no FSM is instantiated.

Decomposition:
- alu_pkg holds:
  - the opcode enum (ALU_ADD..ALU_MUL);
  - flag bit index constants FLAG_SIGN=0, FLAG_ZERO=1, FLAG_CARRY=2, FLAG_OVF=3;
  - the multiplier state enum;
  - a clog2 helper for the count width.
- Sub-module alu_core: purely combinational datapath (a, b, op -> result, flags, illegal), instantiated between S1 and S2.
- The pipeline, handshake and multiplier FSM stay in alu_pipe.

Test Plan:
- ADD: WIDTH=32, ADD a=0xFFFFFFFF, b=1, tag=3 -> two edges later out_result=0, flags carry=1, zero=1, sign=0, overflow=0, out_tag=3.
- SUB overflow: SUB a=0x80000000, b=1 -> result 0x7FFFFFFF, overflow=1, carry=1, sign=0.
- DIFF and SRA:
  - DIFF a=0x0000F0F0, b=0x0000F0B0 -> result 6.
  - DIFF a=b -> result 0, zero=1.
  - SRA a=0x80000000, b=40 -> 0xFFFFFFFF.
- Backpressure: stream ops 0..9 with out_ready low for 3 cycles mid-stream -> no loss or duplication, out_* stable while stalled, order preserved, in_ready=0 when both stages are full.
- Illegal and reset:
  - op 12 -> out_illegal=1, result 0.
  - Assert rst with both stages valid -> next cycle out_valid=0 and every output 0.
- MUL (ALU_PIPE_MUL_EN): MUL 0x1234 x 0x10 -> 0x12340 after WIDTH+2 cycles; in_ready=0 during RUN; rst in RUN returns to IDLE with no output.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU: opcodes, flag bit positions,
// multiplier FSM states and a constant-width helper.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_SLL  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SLA  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_DIFF = 4'd8,
        ALU_INC  = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    localparam int FLAG_SIGN  = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath between S1 and S2: a, b, op -> result, flags, illegal.
// With ALU_PIPE_MUL_EN defined, op MUL forwards the product from the pipe's multiplier.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
`ifdef ALU_PIPE_MUL_EN
    input  logic [WIDTH-1:0] mul_prod,
`endif
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);

    localparam int SH_W = clog2(WIDTH);

    logic [WIDTH-1:0] add_x, add_y, diff;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic [SH_W-1:0]  sh_amt;
    logic             big_shift;
    logic             carry, ovf;

    // SUB and INC reuse the single adder by steering its operands and carry-in.
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
        case (op)
            ALU_SUB: begin
                add_y   = ~b;
                add_cin = 1'b1;
            end
            ALU_INC: begin
                add_x   = b;
                add_y   = '0;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign add_sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    assign sh_amt    = b[SH_W-1:0];
    assign big_shift = |b[WIDTH-1:SH_W];
    assign diff      = a ^ b;

    always_comb begin
        result  = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_INC: begin
                result = add_sum[WIDTH-1:0];
                carry  = add_sum[WIDTH];
                ovf    = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != add_x[WIDTH-1]);
            end
            ALU_AND:          result = a & b;
            ALU_XOR:          result = a ^ b;
            ALU_SLL, ALU_SLA: result = big_shift ? '0 : (a << sh_amt);
            ALU_SRL:          result = big_shift ? '0 : (a >> sh_amt);
            ALU_SRA:          result = big_shift ? {WIDTH{a[WIDTH-1]}}
                                                 : $unsigned($signed(a) >>> sh_amt);
            ALU_DIFF: begin
                // Scanning downward leaves the lowest set bit as the final winner.
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (diff[i]) result = WIDTH'(i);
                end
            end
`ifdef ALU_PIPE_MUL_EN
            ALU_MUL:          result = mul_prod;
`endif
            default:          illegal = 1'b1;
        endcase

        flags = '0;
        if (!illegal) begin
            flags[FLAG_OVF]   = ovf;
            flags[FLAG_CARRY] = carry;
            flags[FLAG_ZERO]  = (result == '0);
            flags[FLAG_SIGN]  = result[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline (S1 operands, S2 result) around alu_core.
// Optional iterative shift-add multiplier enabled by ALU_PIPE_MUL_EN.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [3:0]       s2_flags_q, s2_flags_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_illegal_q, s2_illegal_d;

    logic             op_done, s1_adv, in_xfer;
    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;
    logic             core_illegal;

`ifdef ALU_PIPE_MUL_EN
    localparam int CNT_W = clog2(WIDTH);

    mul_state_e       mul_state_q, mul_state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [WIDTH-1:0] mul_acc_q, mul_acc_d;
    logic [WIDTH-1:0] mul_mcand_q, mul_mcand_d;
    logic [WIDTH-1:0] mul_mplier_q, mul_mplier_d;

    assign op_done = (s1_op_q != ALU_MUL) || (mul_state_q == MUL_DONE);

    always_comb begin
        mul_state_d  = mul_state_q;
        mul_cnt_d    = mul_cnt_q;
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        case (mul_state_q)
            MUL_IDLE: begin
                if (s1_valid_q && (s1_op_q == ALU_MUL)) begin
                    mul_state_d  = MUL_RUN;
                    mul_cnt_d    = '0;
                    mul_acc_d    = '0;
                    mul_mcand_d  = s1_a_q;
                    mul_mplier_d = s1_b_q;
                end
            end
            MUL_RUN: begin
                if (mul_mplier_q[0]) mul_acc_d = mul_acc_q + mul_mcand_q;
                mul_mcand_d  = mul_mcand_q << 1;
                mul_mplier_d = mul_mplier_q >> 1;
                mul_cnt_d    = mul_cnt_q + 1'b1;
                if (mul_cnt_q == CNT_W'(WIDTH - 1)) mul_state_d = MUL_DONE;
            end
            MUL_DONE: begin
                if (s1_adv) mul_state_d = MUL_IDLE;
            end
            default: mul_state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_state_q  <= MUL_IDLE;
            mul_cnt_q    <= '0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
        end else begin
            mul_state_q  <= mul_state_d;
            mul_cnt_q    <= mul_cnt_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
        end
    end
`else
    assign op_done = 1'b1;
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a       (s1_a_q),
        .b       (s1_b_q),
        .op      (s1_op_q),
`ifdef ALU_PIPE_MUL_EN
        .mul_prod(mul_acc_q),
`endif
        .result  (core_result),
        .flags   (core_flags),
        .illegal (core_illegal)
    );

    // Gating with rst keeps in_ready low during the reset cycle itself.
    assign s1_adv   = s1_valid_q && op_done && (!s2_valid_q || out_ready);
    assign in_ready = !rst && (!s1_valid_q || s1_adv);
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = in_op;
            s1_tag_d   = in_tag;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_flags_d   = s2_flags_q;
        s2_tag_d     = s2_tag_q;
        s2_illegal_d = s2_illegal_q;
        if (s1_adv) begin
            s2_valid_d   = 1'b1;
            s2_result_d  = core_result;
            s2_flags_d   = core_flags;
            s2_tag_d     = s1_tag_q;
            s2_illegal_d = core_illegal;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= '0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_flags_q   <= '0;
            s2_tag_q     <= '0;
            s2_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_flags_q   <= s2_flags_d;
            s2_tag_q     <= s2_tag_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_flags   = s2_flags_q;
    assign out_tag     = s2_tag_q;
    assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: scoreboard of model results pushed on input
// transfer and compared on output transfer, plus stall, reset and latency checks.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic [3:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_tag    (out_tag),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        logic [3:0]  tag;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_out = 0;
    bit          last_in_xfer = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_result;
    logic [3:0]  prev_flags, prev_tag;
    logic        prev_illegal;
    logic [31:0] st_a[10], st_b[10];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag);
        exp_t        e;
        logic [32:0] wide;
        logic [31:0] r, x;
        logic        c, v, ill, found;
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0; found = 1'b0;
        case (op)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[31:0];
                c = wide[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4, 4'd6: r = (b >= 32) ? 32'd0 : (a << b);
            4'd5: r = (b >= 32) ? 32'd0 : (a >> b);
            4'd7: begin
                if (b >= 32) r = {32{a[31]}};
                else r = a[31] ? ~((~a) >> b) : (a >> b);
            end
            4'd8: begin
                x = a ^ b;
                for (int i = 0; i < 32; i++) begin
                    if (!found && x[i]) begin
                        r = 32'(i);
                        found = 1'b1;
                    end
                end
            end
            4'd9: begin
                r = b + 32'd1;
                c = (b == 32'hFFFF_FFFF);
                v = (b == 32'h7FFF_FFFF);
            end
`ifdef ALU_PIPE_MUL_EN
            4'd10: r = a * b;
`endif
            default: ill = 1'b1;
        endcase
        e.result  = r;
        e.flags   = ill ? 4'd0 : {v, c, (r == 32'd0), r[31]};
        e.tag     = tag;
        e.illegal = ill;
        return e;
    endfunction

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        last_in_xfer = 0;
        if (!rst) begin
            if (prev_stall) begin
                check("hold_result", out_result, prev_result);
                check("hold_flags", out_flags, prev_flags);
                check("hold_tag", out_tag, prev_tag);
                check("hold_illegal", out_illegal, prev_illegal);
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_op, in_a, in_b, in_tag));
                last_in_xfer = 1;
            end
            if (out_valid && out_ready) begin
                check("out_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", out_result, e.result);
                    check("flags", out_flags, e.flags);
                    check("tag", out_tag, e.tag);
                    check("illegal", out_illegal, e.illegal);
                    n_out++;
                end
            end
            prev_stall   = out_valid && !out_ready;
            prev_result  = out_result;
            prev_flags   = out_flags;
            prev_tag     = out_tag;
            prev_illegal = out_illegal;
        end else begin
            prev_stall = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (last_in_xfer) break;
        end
        check("send_accepted", last_in_xfer, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int idx;
        int out_base;
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_flags", out_flags, 0);
        rst = 1'b0;
        cycle();
        check("post_rst_in_ready", in_ready, 1);

        // ADD with carry-out and zero result; latency and exact flags by hand.
        out_ready = 1'b1;
        send(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 4'd3);
        check("add_lat_s1", out_valid, 0);
        cycle();
        check("add_lat_s2", out_valid, 1);
        check("add_result", out_result, 32'd0);
        check("add_flags", out_flags, 4'b0110);
        check("add_tag", out_tag, 4'd3);
        drain();

        send(ALU_SUB, 32'h8000_0000, 32'd1, 4'd5);
        cycle();
        check("sub_result", out_result, 32'h7FFF_FFFF);
        check("sub_flags", out_flags, 4'b1100);
        drain();
        send(ALU_DIFF, 32'h0000_F0F0, 32'h0000_F0B0, 4'd6);
        cycle();
        check("diff_result", out_result, 32'd6);
        drain();
        send(ALU_DIFF, 32'h1234_5678, 32'h1234_5678, 4'd7);
        send(ALU_SRA, 32'h8000_0000, 32'd40, 4'd8);
        send(ALU_SRA, 32'h8000_0000, 32'd4, 4'd9);
        send(ALU_SRL, 32'hF000_000F, 32'd32, 4'd10);
        send(ALU_INC, 32'd0, 32'h7FFF_FFFF, 4'd11);
        send(ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd12);
        send(4'd12, 32'h1111_1111, 32'h2222_2222, 4'd13);
        send(4'd10, 32'h0000_1234, 32'h0000_0010, 4'd14);
        drain();

        // Continuous stream of ops 0..9 with a three-cycle downstream stall.
        for (int i = 0; i < 10; i++) begin
            st_a[i] = $urandom;
            st_b[i] = (i >= 4 && i <= 7) ? 32'($urandom_range(0, 40)) : $urandom;
        end
        idx = 0;
        out_base = n_out;
        for (int cyc = 0; cyc < 80 && (idx < 10 || sb.size() != 0); cyc++) begin
            if (idx < 10) begin
                in_valid = 1'b1; in_op = 4'(idx); in_a = st_a[idx]; in_b = st_b[idx];
                in_tag = 4'(idx);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(cyc >= 4 && cyc < 7);
            cycle();
            if (cyc == 2) check("bp_throughput", last_in_xfer, 1);
            if (last_in_xfer) idx++;
            if (cyc == 6) begin
                check("bp_in_ready_full", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", n_out - out_base, 10);
        check("bp_sb_empty", sb.size(), 0);

        // Reset with both stages occupied discards everything.
        out_ready = 1'b0;
        send(ALU_ADD, 32'd1, 32'd2, 4'd1);
        send(ALU_XOR, 32'd3, 32'd5, 4'd2);
        check("rst_pre_full", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_cycle_in_ready", in_ready, 0);
        cycle();
        rst = 1'b0;
        sb.delete();
        check("rst2_out_valid", out_valid, 0);
        check("rst2_out_result", out_result, 0);
        check("rst2_out_flags", out_flags, 0);
        check("rst2_out_tag", out_tag, 0);
        check("rst2_out_illegal", out_illegal, 0);
        out_ready = 1'b1;
        out_base = n_out;
        for (int k = 0; k < 4; k++) cycle();
        check("rst2_no_output", n_out - out_base, 0);
        check("rst2_in_ready", in_ready, 1);

`ifdef ALU_PIPE_MUL_EN
        send(ALU_MUL, 32'h0000_1234, 32'h0000_0010, 4'd9);
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) break;
            if (k == 3) check("mul_in_ready_run", in_ready, 0);
            cycle();
            lat++;
        end
        check("mul_latency", lat, WIDTH + 2);
        check("mul_result", out_result, 32'h0001_2340);
        drain();

        send(ALU_MUL, 32'h0000_0007, 32'h0000_0009, 4'd4);
        for (int k = 0; k < 5; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        out_base = n_out;
        for (int k = 0; k < WIDTH + 5; k++) cycle();
        check("mul_rst_no_output", n_out - out_base, 0);
        check("mul_rst_out_valid", out_valid, 0);
        send(ALU_ADD, 32'd20, 32'd22, 4'd2);
        drain();
`else
        lat = 0;
        check("mul_disabled_lat", lat, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
